ahb_frame_read_sequencer: RTL
=============================

// Module: ahb_frame_read_sequencer
// PURPOSE
//  AHB-Lite read-master address sequencer for one image frame: walks columns (4-byte beats) then rows.
//  Row base advances by a programmable stride. Issues single NONSEQ word reads and returns HRDATA as a
//  valid/data stream. Sits between the edge-detect control FSM (start/done) and the AHB bus.
//  Row-end detection matches the column counter's rollover at (length-4).
// PARAMETERS
//  ADDR_W   32  AHB address width; all address arithmetic is modulo 2^ADDR_W
//  DIM_W    16  width of length/width/stride and of the internal column/row counters
// PORTS
//  HCLK         in   1       clock, all logic on rising edge
//  HRESET       in   1       asynchronous, active-high reset
//  start        in   1       1-cycle pulse; accepted only in IDLE
//  base_addr    in   ADDR_W  frame start byte address, sampled on accepted start
//  length       in   DIM_W   row length in bytes; bits[1:0] ignored; sampled on start
//  width        in   DIM_W   number of rows; sampled on start
//  stride       in   DIM_W   byte offset between row starts; bits[1:0] ignored; sampled on start
//  hold         in   1       consumer backpressure; blocks issue of new address phases
//  HREADY       in   1       AHB ready, qualifies address and data phases
//  HRDATA       in   32      AHB read data
//  HRESP        in   1       AHB response; 1 = ERROR
//  HADDR        out  ADDR_W  address phase address
//  HTRANS       out  2       2'b00 IDLE or 2'b10 NONSEQ only
//  HWRITE       out  1       tied 0
//  HSIZE        out  3       tied 3'b010 (word)
//  rdata        out  32      captured read word
//  rdata_valid  out  1       1-cycle pulse per returned beat
//  busy         out  1       high from accepted start until done
//  done         out  1       1-cycle pulse at end of frame
//  error        out  1       sticky until next accepted start; set by HRESP=1
// BEHAVIOUR
//  Reset: FSM=IDLE, HADDR=0, HTRANS=IDLE, rdata=0, rdata_valid=0, busy=0, done=0, error=0, counters=0.
//  FSM states IDLE, ISSUE, DRAIN, FINISH.
//  IDLE: start=1 -> latch inputs; col=0, row=0, row_base=base_addr, error=0; busy=1.
//    Zero-size frame (length[DIM_W-1:2]==0 or width==0) -> FINISH.
//    Otherwise -> ISSUE.
//  ISSUE: HTRANS=NONSEQ, HADDR=row_base+col, unless hold=1 (then HTRANS=IDLE, counters frozen).
//    Beat accepted when NONSEQ and HREADY=1. On accept:
//      col!=len4-4: col+=4.
//      col==len4-4 (row end): col=0, row+=1, row_base+=stride4.
//      Row end and row==width-1 (last beat): -> DRAIN.
//    len4 = length & ~3; stride4 = stride & ~3.
//  Data phase of each accepted beat completes on the next HREADY=1 cycle.
//    At completion: rdata<=HRDATA and rdata_valid=1 on the following cycle (1-cycle registered latency).
//  DRAIN: HTRANS=IDLE; when the last data phase completes -> FINISH.
//  FINISH: done=1 for exactly one cycle, busy=0 -> IDLE. Zero-size frame: done 1 cycle after start.
//  HRESP=1 in a data phase: error=1, rdata_valid not asserted for that beat, HTRANS=IDLE.
//    Then -> DRAIN (outstanding phase completes) -> FINISH (done still pulses).
//  start while busy: ignored, no effect on latched parameters.
//  HREADY=0: HADDR/HTRANS held stable; counters do not advance.
//  hold=1 never cancels an address phase already presented with HREADY=0.
//  hold=1 only takes effect for a new address phase.
//  Address wrap past 2^ADDR_W rolls over silently. row_base uses ADDR_W-bit add of zero-extended stride4.
//  At most one outstanding data phase; pipelined: next address overlaps the previous data phase.
//  HRESET mid-frame: all state to reset values immediately; no done pulse; HTRANS=IDLE asynchronously.
// TESTING
//  1. base=0x1000, length=16, width=2, stride=16, HREADY=1:
//     HADDR 1000,1004,...,101C on 8 consecutive cycles; 8 rdata_valid in order; done 2 cycles after last addr.
//  2. base=0x2000, length=8, width=3, stride=0x100:
//     HADDR 2000,2004,2100,2104,2200,2204; busy high throughout; done once.
//  3. length=4, width=1 with HREADY low 3 cycles during the data phase:
//     HADDR stable, one rdata_valid after HREADY returns, then done.
//  4. length=0 or width=0 (also length=3): no NONSEQ issued, done exactly 1 cycle after start, error=0.
//  5. HRESP=1 on beat 2 of a 4-beat frame: error=1, HTRANS goes IDLE, done pulses, 1 rdata_valid.
//     A second start clears error.
//  6. HRESET asserted mid-frame for 1 cycle: outputs at reset values; subsequent start runs full frame correctly.
//     Separately: hold=1 for 5 cycles mid-row gives no address skipped or repeated.

Source files
------------

// File: rtl/ahb_frame_read_sequencer.sv
// ahb_frame_read_sequencer
//   AHB-Lite read master that walks one image frame: 4-byte word beats across
//   a row, then advances the row base by a programmable stride. Every beat is
//   a single NONSEQ word read. Returned words are presented as a
//   valid/data stream. The block is started by a control FSM (start) and
//   reports completion back to it (done).
//
// Ports
//   HCLK, HRESET          clock (rising edge), asynchronous active-high reset
//   start                 1-cycle request, accepted only while idle
//   base_addr             frame start byte address (sampled on start)
//   length, width, stride row bytes, row count, row pitch (sampled on start)
//   hold                  consumer backpressure, blocks new address phases
//   HREADY, HRDATA, HRESP AHB slave response
//   HADDR, HTRANS, HWRITE, HSIZE  AHB address phase (read, word, NONSEQ/IDLE)
//   rdata, rdata_valid    returned word stream (1-cycle valid pulse per beat)
//   busy, done, error     frame status; error is sticky until the next start
module ahb_frame_read_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  length,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  stride,
  input  logic              hold,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic              HRESP,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [1:0]        state;
  logic [DIM_W-1:0]  len4;
  logic [DIM_W-1:0]  stride4;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr;
  logic              pending;
  logic              dphase;
  logic              error_r;
  logic [31:0]       rdata_r;
  logic              rvld;

  logic              err_now;
  logic              issue;
  logic              accept;
  logic              complete;
  logic              row_end;
  logic              last_beat;
  logic              zero_frame;
  logic [ADDR_W-1:0] stride_ext;
  logic [ADDR_W-1:0] next_row_base;

  // An ERROR response on the outstanding data phase cancels whatever address
  // phase is on the bus right now, so no further beat is accepted.
  assign err_now    = dphase & HRESP;

  // Once an address phase has been presented with HREADY low (pending), it
  // must stay on the bus until accepted; hold only gates fresh address phases.
  assign issue      = (state == S_ISSUE) & ~err_now & (pending | ~hold);
  assign accept     = issue & HREADY;
  assign complete   = dphase & HREADY;

  assign row_end    = (col == (len4 - DIM_W'(4)));
  assign last_beat  = row_end & (row == (rows - DIM_W'(1)));
  assign zero_frame = (length[DIM_W-1:2] == '0) | (width == '0);

  assign stride_ext    = ADDR_W'(stride4);
  assign next_row_base = row_base + stride_ext;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      len4     <= '0;
      stride4  <= '0;
      rows     <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
      pending  <= 1'b0;
      dphase   <= 1'b0;
      error_r  <= 1'b0;
      rdata_r  <= '0;
      rvld     <= 1'b0;
    end else begin
      rvld    <= 1'b0;
      pending <= issue & ~HREADY;

      // At most one data phase in flight; a new accept overlaps the
      // completion of the previous one.
      if (accept) begin
        dphase <= 1'b1;
      end else if (HREADY) begin
        dphase <= 1'b0;
      end

      if (err_now) begin
        error_r <= 1'b1;
      end
      if (complete && !HRESP) begin
        rdata_r <= HRDATA;
        rvld    <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len4     <= length & ~DIM_W'(3);
            stride4  <= stride & ~DIM_W'(3);
            rows     <= width;
            col      <= '0;
            row      <= '0;
            row_base <= base_addr;
            addr     <= base_addr;
            error_r  <= 1'b0;
            state    <= zero_frame ? S_FINISH : S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (err_now) begin
            state <= S_DRAIN;
          end else if (accept) begin
            if (row_end) begin
              col      <= '0;
              row      <= row + DIM_W'(1);
              row_base <= next_row_base;
              // HADDR keeps the final beat's address while draining.
              if (last_beat) begin
                state <= S_DRAIN;
              end else begin
                addr <= next_row_base;
              end
            end else begin
              col  <= col + DIM_W'(4);
              addr <= addr + ADDR_W'(4);
            end
          end
        end

        S_DRAIN: begin
          if (!dphase || HREADY) begin
            state <= S_FINISH;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign HADDR       = addr;
  assign HTRANS      = issue ? TR_NONSEQ : TR_IDLE;
  assign HWRITE      = 1'b0;
  assign HSIZE       = 3'b010;
  assign rdata       = rdata_r;
  assign rdata_valid = rvld;
  assign busy        = (state == S_ISSUE) | (state == S_DRAIN);
  assign done        = (state == S_FINISH);
  assign error       = error_r;

endmodule
